fetch_sequencer: RTL and testbench

//  Multi-cycle instruction-fetch controller. Owns the PC and issues one request at a time to the

---
 rtl/fetch_sequencer.sv | 134 +++++++++++++
 tb/tb_fetch_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multi-cycle instruction fetch controller
// One outstanding request at a time; held instruction handed to decode; redirect squashes in-flight data.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] imem_addr_q;
    logic [31:0] instr_out_q;
    logic [31:0] instr_pc_q;
    logic [31:0] fetch_count_q;
    logic        imem_req_q;
    logic        instr_valid_q;
    logic        misalign_q;
    logic        squash_q;

    logic [31:0] target_d;
    logic [31:0] pc_inc_d;
    logic        transfer_d;

    assign target_d   = {redirect_pc[31:2], 2'b00};
    assign pc_inc_d   = pc_q + PC_STEP;
    assign transfer_d = instr_valid_q & instr_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            imem_addr_q   <= RESET_PC;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_out_q   <= 32'h0;
            instr_pc_q    <= 32'h0;
            misalign_q    <= 1'b0;
            fetch_count_q <= 32'h0;
            squash_q      <= 1'b0;
        end else begin
            imem_req_q <= 1'b0;
            misalign_q <= redirect_valid & (redirect_pc[1:0] != 2'b00);
            // The request address is registered on entry to REQ, so it is frozen until the response.
            case (state_q)
                IDLE: begin
                    state_q    <= REQ;
                    imem_req_q <= 1'b1;
                    if (redirect_valid) begin
                        pc_q        <= target_d;
                        imem_addr_q <= target_d;
                    end else begin
                        imem_addr_q <= pc_q;
                    end
                end
                REQ: begin
                    state_q <= WAIT;
                    if (redirect_valid) begin
                        pc_q     <= target_d;
                        squash_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc_q <= target_d;
                        if (imem_valid) begin
                            squash_q    <= 1'b0;
                            state_q     <= REQ;
                            imem_req_q  <= 1'b1;
                            imem_addr_q <= target_d;
                        end else begin
                            squash_q <= 1'b1;
                        end
                    end else if (imem_valid) begin
                        if (squash_q) begin
                            squash_q    <= 1'b0;
                            state_q     <= REQ;
                            imem_req_q  <= 1'b1;
                            imem_addr_q <= pc_q;
                        end else begin
                            instr_out_q   <= imem_rdata;
                            instr_pc_q    <= pc_q;
                            instr_valid_q <= 1'b1;
                            state_q       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid || transfer_d) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= REQ;
                        imem_req_q    <= 1'b1;
                        if (transfer_d) begin
                            fetch_count_q <= fetch_count_q + 32'd1;
                        end
                        // A redirect wins over sequential advance even when the held word transfers.
                        if (redirect_valid) begin
                            pc_q        <= target_d;
                            imem_addr_q <= target_d;
                        end else begin
                            pc_q        <= pc_inc_d;
                            imem_addr_q <= pc_inc_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = imem_addr_q;
    assign instr_valid  = instr_valid_q;
    assign instr_out    = instr_out_q;
    assign instr_pc     = instr_pc_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
// Memory responder plus a next-expected-PC/count reference model checked every cycle.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    bit          rand_lat = 1'b0;
    bit          pending = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;
    logic [31:0] req_log[$];
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] m_count = 32'h0;
    bit          mis_exp = 1'b0;
    logic [31:0] a;
    logic [31:0] cnt_b;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag, output logic [31:0] addr);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (imem_req) break;
        end
        chk(tag, {31'b0, imem_req}, 32'd1);
        addr = imem_addr;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (instr_valid) break;
        end
        chk(tag, {31'b0, instr_valid}, 32'd1);
    endtask

    // Memory: responds to each request after the chosen latency with a one-cycle valid.
    initial begin
        imem_valid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            imem_valid = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            if (!reset_n) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    if (cnt == 1) begin
                        imem_valid = 1'b1;
                        imem_rdata = word_at(paddr);
                        pending    = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (imem_req) begin
                    pending = 1'b1;
                    paddr   = imem_addr;
                    cnt     = rand_lat ? int'($urandom_range(1, 4)) : lat;
                    req_log.push_back(imem_addr);
                end
            end
        end
    end

    // Reference model: next instruction PC the decoder should see, and the transfer count.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                exp_pc  = 32'h0;
                m_count = 32'h0;
                mis_exp = 1'b0;
            end else begin
                chk("misalign", {31'b0, misalign_err}, {31'b0, mis_exp});
                chk("count", fetch_count, m_count);
                if (pending) chk("addr_stable", imem_addr, paddr);
                if (instr_valid) begin
                    chk("instr_pc", instr_pc, exp_pc);
                    chk("instr_out", instr_out, word_at(exp_pc));
                end
                mis_exp = redirect_valid && (redirect_pc[1:0] != 2'b00);
                if (instr_valid && instr_ready) begin
                    m_count = m_count + 32'd1;
                    exp_pc  = exp_pc + 32'd4;
                end
                if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_out", instr_out, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_mis", {31'b0, misalign_err}, 32'd0);
        chk("rst_count", fetch_count, 32'h0);

        // Sequential fetch at latency 1
        lat = 1; req_log.delete(); instr_ready = 1'b1; reset_n = 1'b1;
        for (int i = 0; i < 100 && fetch_count != 32'd4; i++) @(negedge clk);
        chk("t1_count", fetch_count, 32'd4);
        for (int i = 0; i < 4; i++) chk("t1_req_addr", req_log[i], 32'(i * 4));

        // Decode stall in HOLD
        lat = 3; instr_ready = 1'b0;
        wait_valid("t2_valid");
        repeat (5) begin
            @(negedge clk);
            chk("t2_hold_valid", {31'b0, instr_valid}, 32'd1);
            chk("t2_no_req", {31'b0, imem_req}, 32'd0);
            chk("t2_hold_out", instr_out, word_at(exp_pc));
        end
        instr_ready = 1'b1;

        // Redirect while waiting for 0x8
        reset_n = 1'b0; repeat (2) @(negedge clk);
        reset_n = 1'b1; lat = 3; instr_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h8) break;
        end
        chk("t3_req8", imem_addr, 32'h8);
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk); redirect_valid = 1'b0;
        wait_req("t3_req", a);
        chk("t3_addr", a, 32'h40);
        wait_valid("t3_valid");
        chk("t3_pc", instr_pc, 32'h40);

        // Redirect coinciding with a transfer in HOLD
        instr_ready = 1'b0;
        wait_valid("t4_valid");
        cnt_b = m_count;
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        @(negedge clk);
        redirect_valid = 1'b0; instr_ready = 1'b0;
        chk("t4_count", fetch_count, cnt_b + 32'd1);
        chk("t4_req", {31'b0, imem_req}, 32'd1);
        chk("t4_addr", imem_addr, 32'h80);

        // Misaligned redirect
        wait_valid("t5_valid");
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("t5_mis_pulse", {31'b0, misalign_err}, 32'd1);
        chk("t5_req", {31'b0, imem_req}, 32'd1);
        chk("t5_addr", imem_addr, 32'h100);
        @(negedge clk);
        chk("t5_mis_end", {31'b0, misalign_err}, 32'd0);
        wait_valid("t5_valid2");
        chk("t5_pc", instr_pc, 32'h100);

        // Reset mid-WAIT, then counter wrap
        instr_ready = 1'b1; lat = 3;
        wait_req("t6_req", a);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("t6_rst_count", fetch_count, 32'h0);
        chk("t6_rst_addr", imem_addr, 32'h0);
        chk("t6_rst_req", {31'b0, imem_req}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1; instr_ready = 1'b0; lat = 1;
        wait_req("t6_req2", a);
        chk("t6_addr", a, 32'h0);
        chk("t6_count0", fetch_count, 32'h0);
        wait_valid("t6_valid");
        force dut.fetch_count_q = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        #1 release dut.fetch_count_q;
        @(negedge clk); instr_ready = 1'b1;
        @(negedge clk); instr_ready = 1'b0;
        chk("t6_wrap", fetch_count, 32'h0);

        // Randomized traffic against the model
        rand_lat = 1'b1;
        repeat (400) begin
            @(negedge clk);
            instr_ready    = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 32'($urandom_range(0, 1023));
        end
        @(negedge clk); redirect_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
